// File: rtl/adio_i2s_tx.sv
// adio_i2s_tx: single-clock audio DAC serializer.
// BCK and LRCK are plain registers clocked by iCLK_18_4, so no derived clock
// domain exists. Host frames arrive over a valid/ready port into a one-deep
// holding buffer. At each frame boundary the buffer moves into the frame
// register. If the buffer is empty at that point, the frame is sent as zeros
// and the sticky underrun flag is raised. The serial format can be I2S or
// left-justified. Slot bits past DATA_WIDTH are sent as zeros.
module adio_i2s_tx #(
  parameter int DATA_WIDTH  = 16,
  parameter int SLOT_WIDTH  = 16,
  parameter int CHANNEL_NUM = 2,
  parameter int DIV_WIDTH   = 8
) (
  input  logic                                iCLK_18_4,
  input  logic                                iRST_N,
  input  logic [DIV_WIDTH-1:0]                iBCK_HALF,
  input  logic                                iMODE,
  input  logic                                iMUTE,
  input  logic [CHANNEL_NUM*DATA_WIDTH-1:0]   iSAMPLE_DATA,
  input  logic                                iSAMPLE_VALID,
  output logic                                oSAMPLE_READY,
  input  logic                                iCLR_UNDERRUN,
  output logic                                oUNDERRUN,
  output logic                                oAUD_BCK,
  output logic                                oAUD_LRCK,
  output logic                                oAUD_DATA
);

  localparam int FRAME_W    = CHANNEL_NUM * DATA_WIDTH;
  localparam int FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS);

  localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0]     SLOT_START = CNT_W'(SLOT_WIDTH);
  localparam logic [FRAME_W-1:0]   FRAME_ONE  = FRAME_W'(1);

  logic [DIV_WIDTH-1:0] r_divCnt;
  logic                 r_bck;
  logic [CNT_W-1:0]     r_bitCnt;
  logic                 r_modeQ;
  logic                 r_bufFull;
  logic [FRAME_W-1:0]   r_buffer;
  logic [FRAME_W-1:0]   r_frame;
  logic                 r_ljBit;
  logic                 r_lrck;
  logic                 r_data;
  logic                 r_underrun;

  logic                 w_tick;
  logic                 w_fall;
  logic                 w_boundary;
  logic                 w_accept;
  logic [CNT_W-1:0]     w_cntNext;
  logic                 w_modeNext;
  logic [FRAME_W-1:0]   w_frameNext;
  logic                 w_slot1;
  logic                 w_streamBit;

  // This returns the left-justified stream bit for one bit position of a frame.
  // Slot 0 carries ch0. Slot 1 carries ch1, or ch0 again for mono.
  // Each sample is sent MSB first. Positions past DATA_WIDTH give zero.
  function automatic logic streamBit(input logic [FRAME_W-1:0] frame,
                                     input logic [CNT_W-1:0]   cnt);
    int   pos;
    int   shiftAmt;
    logic slot1;
    logic bitVal;
    slot1  = (cnt >= SLOT_START);
    pos    = slot1 ? (int'(cnt) - SLOT_WIDTH) : int'(cnt);
    bitVal = 1'b0;
    if (pos < DATA_WIDTH) begin
      shiftAmt = ((slot1 && (CHANNEL_NUM == 2)) ? DATA_WIDTH : 0) + DATA_WIDTH - 1 - pos;
      bitVal   = |(frame & (FRAME_ONE << shiftAmt));
    end
    return bitVal;
  endfunction

  // The >= compare lets a lowered iBCK_HALF take effect at once, without waiting for the counter to wrap.
  assign w_tick      = (r_divCnt >= iBCK_HALF);
  assign w_fall      = w_tick && r_bck;
  assign w_boundary  = w_fall && (r_bitCnt == CNT_LAST);
  assign w_accept    = iSAMPLE_VALID && !r_bufFull;
  assign w_cntNext   = (r_bitCnt == CNT_LAST) ? '0 : (r_bitCnt + CNT_W'(1));
  assign w_modeNext  = w_boundary ? iMODE : r_modeQ;
  assign w_frameNext = w_boundary ? ((r_bufFull && !iMUTE) ? r_buffer : '0) : r_frame;
  assign w_slot1     = (w_cntNext >= SLOT_START);
  assign w_streamBit = streamBit(w_frameNext, w_cntNext);

  // The bit clock divider toggles BCK each time the half-period count expires.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_divCnt <= '0;
      r_bck    <= 1'b0;
    end else if (w_tick) begin
      r_divCnt <= '0;
      r_bck    <= ~r_bck;
    end else begin
      r_divCnt <= r_divCnt + DIV_WIDTH'(1);
    end
  end

  // On each BCK falling edge, this block advances the bit position and updates the word select and data pins.
  // At a frame boundary it also latches the mode and the new frame.
  // In I2S mode the data pin carries the previous left-justified bit.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_bitCnt <= CNT_LAST;
      r_modeQ  <= 1'b0;
      r_frame  <= '0;
      r_ljBit  <= 1'b0;
      r_lrck   <= 1'b0;
      r_data   <= 1'b0;
    end else if (w_fall) begin
      r_bitCnt <= w_cntNext;
      r_lrck   <= w_modeNext ? ~w_slot1 : w_slot1;
      r_ljBit  <= w_streamBit;
      r_data   <= w_modeNext ? w_streamBit : r_ljBit;
      if (w_boundary) begin
        r_modeQ <= iMODE;
        r_frame <= w_frameNext;
      end
    end
  end

  // The holding buffer empties at a frame boundary and refills on a handshake.
  // An accept on the boundary clock goes into the buffer, where it waits for the next frame.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_bufFull <= 1'b0;
      r_buffer  <= '0;
    end else if (w_boundary && r_bufFull) begin
      r_bufFull <= 1'b0;
    end else if (w_accept) begin
      r_bufFull <= 1'b1;
      r_buffer  <= iSAMPLE_DATA;
    end
  end

  // The sticky underrun flag is set when a boundary finds the buffer empty.
  // If a set and a clear land on the same clock, the set wins.
  always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_underrun <= 1'b0;
    end else if (w_boundary && !r_bufFull) begin
      r_underrun <= 1'b1;
    end else if (iCLR_UNDERRUN) begin
      r_underrun <= 1'b0;
    end
  end

  assign oSAMPLE_READY = ~r_bufFull;
  assign oUNDERRUN     = r_underrun;
  assign oAUD_BCK      = r_bck;
  assign oAUD_LRCK     = r_lrck;
  assign oAUD_DATA     = r_data;

endmodule
